// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock_ctrl timekeeping block: mode encodings,
// field limits and the wrap-around increment used by every time field.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_SEC  = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_HOUR = 2'd3
  } mode_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  // Hours are passed zero-extended to 6 bits so one helper serves all fields.
  function automatic logic [5:0] inc_wrap(input logic [5:0] val, input logic [5:0] max);
    return (val == max) ? 6'd0 : val + 6'd1;
  endfunction

  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      MODE_RUN:      return MODE_SET_SEC;
      MODE_SET_SEC:  return MODE_SET_MIN;
      MODE_SET_MIN:  return MODE_SET_HOUR;
      default:       return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_ctrl_tick_gen.sv
// Programmable tick generator: emits a one-cycle enable every num cycles
// while enabled; the counter is held at zero when disabled or cleared.
module tick_gen #(
  parameter int NUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_W-1:0] num,
  input  logic             en,
  input  logic             clr,
  output logic             tick_en
);

  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    // >= rather than == so a num lowered below the running count ticks at once.
    hit     = (num != '0) && (cnt_q >= num - NUM_W'(1));
    tick_en = en && !clr && hit;
    cnt_d   = cnt_q + NUM_W'(1);
    if (clr || !en || (num == '0) || hit) begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Timekeeping top: RUN/SET mode FSM, seconds/minutes/hours chain advanced by
// the tick enable, and the registered tick output.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int NUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_W-1:0] num,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_clr,
  output logic [5:0]       sec,
  output logic [5:0]       min,
  output logic [4:0]       hour,
  output logic [1:0]       mode,
  output logic             tick
);

  mode_e      mode_q, mode_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       tick_q;
  logic       tick_en;

  tick_gen #(.NUM_W(NUM_W)) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .num     (num),
    .en      (mode_q == MODE_RUN),
    .clr     (btn_clr),
    .tick_en (tick_en)
  );

  always_comb begin
    mode_d = mode_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;

    if (btn_clr) begin
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else begin
      if (btn_mode) begin
        mode_d = next_mode(mode_q);
      end

      // Ticks only occur in RUN, so they never collide with btn_inc edits.
      if (tick_en) begin
        sec_d = inc_wrap(sec_q, SEC_MAX);
        if (sec_q == SEC_MAX) begin
          min_d = inc_wrap(min_q, MIN_MAX);
          if (min_q == MIN_MAX) begin
            hour_d = 5'(inc_wrap({1'b0, hour_q}, {1'b0, HOUR_MAX}));
          end
        end
      end

      if (btn_inc && !btn_mode) begin
        case (mode_q)
          MODE_SET_SEC:  sec_d  = inc_wrap(sec_q, SEC_MAX);
          MODE_SET_MIN:  min_d  = inc_wrap(min_q, MIN_MAX);
          MODE_SET_HOUR: hour_d = 5'(inc_wrap({1'b0, hour_q}, {1'b0, HOUR_MAX}));
          default:       ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_RUN;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      tick_q <= tick_en;
    end
  end

  assign sec  = sec_q;
  assign min  = min_q;
  assign hour = hour_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: a time-of-day model predicts each cycle's
// outputs, which are queued at drive time and compared after the edge.
module tb_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] num = '0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_clr = 1'b0;
  logic [5:0]  sec, min;
  logic [4:0]  hour;
  logic [1:0]  mode;
  logic        tick;

  clock_ctrl #(.NUM_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .num      (num),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_clr  (btn_clr),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       tick;
  } obs_t;

  typedef struct packed {
    logic [31:0] n;
    logic        bm;
    logic        bi;
    logic        bc;
  } stim_t;

  obs_t  sb[$];
  stim_t stim[$];
  int    compared = 0;
  int    mismatched = 0;

  // Model state: time kept as seconds-of-day, fields derived on demand.
  logic [31:0] m_cnt;
  int          m_tod;
  int          m_mode;

  function automatic obs_t snap();
    return {sec, min, hour, mode, tick};
  endfunction

  function automatic void model_reset();
    m_cnt  = '0;
    m_tod  = 0;
    m_mode = 0;
  endfunction

  task automatic model(input stim_t s);
    bit   tk;
    int   fs, fm, fh;
    obs_t e;
    tk = (m_mode == 0) && (s.n != 0) && !s.bc && (m_cnt >= s.n - 32'd1);
    if (s.bc || m_mode != 0 || s.n == 0 || tk) m_cnt = '0;
    else m_cnt = m_cnt + 32'd1;
    if (s.bc) m_tod = 0;
    else if (tk) m_tod = (m_tod + 1) % 86400;
    if (!s.bc && !s.bm && s.bi && m_mode != 0) begin
      fs = m_tod % 60;
      fm = (m_tod / 60) % 60;
      fh = m_tod / 3600;
      if (m_mode == 1) fs = (fs + 1) % 60;
      if (m_mode == 2) fm = (fm + 1) % 60;
      if (m_mode == 3) fh = (fh + 1) % 24;
      m_tod = fh * 3600 + fm * 60 + fs;
    end
    if (!s.bc && s.bm) m_mode = (m_mode + 1) % 4;
    e.sec  = 6'(m_tod % 60);
    e.min  = 6'((m_tod / 60) % 60);
    e.hour = 5'(m_tod / 3600);
    e.mode = 2'(m_mode);
    e.tick = tk;
    sb.push_back(e);
  endtask

  function automatic void add(input logic [31:0] n, input logic bm, input logic bi,
                              input logic bc, input int count);
    for (int i = 0; i < count; i++) stim.push_back({n, bm, bi, bc});
  endfunction

  // Drives one cycle, queues its prediction, and returns #1 after the edge.
  task automatic step(input stim_t s);
    num      = s.n;
    btn_mode = s.bm;
    btn_inc  = s.bi;
    btn_clr  = s.bc;
    model(s);
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_clr  = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = snap();
    compared++;
    if (got !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got %h required %h", got, obs_t'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_run();
    obs_t got, exp;
    int   ticks = 0;
    add(32'd4, 0, 0, 0, 40);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL run_num4: got %h required %h", got, exp);
      end
      if (tick === 1'b1) ticks++;
    end
    compared++;
    if (sec !== 6'd10 || ticks != 10) begin
      mismatched++;
      $display("FAIL run_num4_total: got sec %0d ticks %0d required 10 10", sec, ticks);
    end
  endtask

  task automatic test_rollover();
    obs_t got, exp;
    add(32'd0, 0, 0, 1, 1);
    add(32'd0, 1, 0, 0, 1);
    add(32'd0, 0, 1, 0, 58);
    add(32'd0, 1, 0, 0, 3);
    add(32'd1, 0, 0, 0, 2);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL rollover_min: got %h required %h", got, exp);
      end
    end
    compared++;
    if ({hour, min, sec} !== {5'd0, 6'd1, 6'd0}) begin
      mismatched++;
      $display("FAIL carry_to_min: got %0d:%0d:%0d required 0:1:0", hour, min, sec);
    end

    add(32'd0, 0, 0, 1, 1);
    add(32'd0, 1, 0, 0, 1);
    add(32'd0, 0, 1, 0, 59);
    add(32'd0, 1, 0, 0, 1);
    add(32'd0, 0, 1, 0, 59);
    add(32'd0, 1, 0, 0, 1);
    add(32'd0, 0, 1, 0, 23);
    add(32'd0, 1, 0, 0, 1);
    add(32'd1, 0, 0, 0, 1);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL rollover_day: got %h required %h", got, exp);
      end
    end
    compared++;
    if ({hour, min, sec, tick} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL day_wrap: got %0d:%0d:%0d tick %0d required 0:0:0 tick 1",
               hour, min, sec, tick);
    end
  endtask

  task automatic test_set();
    obs_t got, exp;
    add(32'd0, 0, 0, 1, 1);
    add(32'd0, 1, 0, 0, 1);
    add(32'd0, 0, 1, 0, 61);
    add(32'd0, 1, 0, 0, 2);
    add(32'd0, 0, 1, 0, 25);
    add(32'd0, 1, 1, 0, 1);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL set_fields: got %h required %h", got, exp);
      end
    end
    compared++;
    if ({hour, min, sec, mode} !== {5'd1, 6'd0, 6'd1, 2'd0}) begin
      mismatched++;
      $display("FAIL set_final: got %0d:%0d:%0d mode %0d required 1:0:1 mode 0",
               hour, min, sec, mode);
    end
  endtask

  task automatic test_simultaneous();
    obs_t got, exp;
    add(32'd0, 0, 0, 1, 1);
    add(32'd2, 0, 0, 0, 1);
    add(32'd2, 1, 0, 0, 1);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL mode_on_tick: got %h required %h", got, exp);
      end
    end
    compared++;
    if ({sec, mode, tick} !== {6'd1, 2'd1, 1'b1}) begin
      mismatched++;
      $display("FAIL mode_on_tick_final: got sec %0d mode %0d tick %0d required 1 1 1",
               sec, mode, tick);
    end

    add(32'd0, 1, 0, 0, 3);
    add(32'd2, 0, 0, 0, 1);
    add(32'd2, 0, 0, 1, 1);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL clr_on_tick: got %h required %h", got, exp);
      end
    end
    compared++;
    if ({hour, min, sec, tick} !== {5'd0, 6'd0, 6'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL clr_on_tick_final: got %0d:%0d:%0d tick %0d required 0:0:0 tick 0",
               hour, min, sec, tick);
    end
  endtask

  task automatic test_num_change();
    obs_t got, exp;
    int   idx = 0;
    int   ticks0 = 0;
    add(32'd10, 0, 0, 1, 1);
    add(32'd10, 0, 0, 0, 7);
    add(32'd3, 0, 0, 0, 10);
    add(32'd0, 0, 0, 0, 100);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL num_change: cycle %0d got %h required %h", idx, got, exp);
      end
      if ((idx == 8 || idx == 11) && tick !== 1'b1) begin
        mismatched++;
        $display("FAIL num_drop_tick: cycle %0d got tick %0d required 1", idx, tick);
      end
      if (idx >= 19 && tick === 1'b1) ticks0++;
      idx++;
    end
    compared += 2;
    compared++;
    if (ticks0 != 0) begin
      mismatched++;
      $display("FAIL num_zero: got %0d ticks required 0", ticks0);
    end
  endtask

  task automatic test_async_reset();
    obs_t got, exp;
    add(32'd5, 1, 0, 0, 2);
    add(32'd5, 0, 1, 0, 3);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL pre_reset: got %h required %h", got, exp);
      end
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = snap();
    compared++;
    if (got !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got %h required %h", got, obs_t'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add(32'd1, 0, 0, 0, 3);
    while (stim.size() > 0) begin
      step(stim.pop_front());
      got = snap();
      exp = sb.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL post_reset: got %h required %h", got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_rollover();
    test_set();
    test_simultaneous();
    test_num_change();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
